// File: rtl/dht11_pkg.sv
// ---------------------------------------------------------------------------
// dht11_pkg
//   Shared definitions for the DHT11 single-wire bus master: FSM state
//   encoding, timing unit constants, frame layout and counter widths.
//   The 40-bit frame is shifted in MSB first, so byte 4 is the first byte on
//   the wire (RH integer) and byte 0 is the last (checksum).
// ---------------------------------------------------------------------------
package dht11_pkg;

  localparam int US_PER_MS  = 1000;
  localparam int FRAME_BITS = 40;
  localparam int BIT_CNT_W  = 6;
  localparam int PHASE_W    = 16;

  localparam int unsigned RH_INT_IDX = 4;
  localparam int unsigned RH_DEC_IDX = 3;
  localparam int unsigned T_INT_IDX  = 2;
  localparam int unsigned T_DEC_IDX  = 1;
  localparam int unsigned CSUM_IDX   = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START_LOW,
    ST_RELEASE,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } dht11_state_e;

  // Extracts byte 'idx' (0 = least significant) from a received frame.
  function automatic logic [7:0] frameByte(input logic [FRAME_BITS-1:0] frame,
                                           input int unsigned idx);
    return 8'(frame >> (idx * 8));
  endfunction

endpackage

// File: rtl/dht11_if.sv
// ---------------------------------------------------------------------------
// dht11_if
//   Request/result bundle between the DHT11 driver and its requester.
//   Signals:
//     sample_en    requester -> driver  1-cycle measurement request
//     busy         driver -> requester  measurement in progress
//     data_rdy     driver -> requester  1-cycle strobe, new humidity/temperature
//     humidity     driver -> requester  RH integer byte of last valid frame
//     temperature  driver -> requester  temperature integer byte of last valid frame
//     err          driver -> requester  1-cycle strobe, timeout or bad checksum
//   Modports: master (requester side), slave (driver side).
// ---------------------------------------------------------------------------
interface dht11_if;
  logic       sample_en;
  logic       busy;
  logic       data_rdy;
  logic [7:0] humidity;
  logic [7:0] temperature;
  logic       err;

  modport master (
    output sample_en,
    input  busy, data_rdy, humidity, temperature, err
  );

  modport slave (
    input  sample_en,
    output busy, data_rdy, humidity, temperature, err
  );
endinterface

// File: rtl/dht11_us_tick.sv
// ---------------------------------------------------------------------------
// dht11_us_tick
//   Free-running divider producing a registered 1-cycle pulse every
//   microsecond (every CLK_FREQ_HZ/1_000_000 clocks).
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset
//     tick   out  1 us strobe
//   With a 1 MHz clock the strobe is simply held high.
// ---------------------------------------------------------------------------
module dht11_us_tick #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] divCnt_q;
  logic          tick_q;

  // Wrap the divider at DIV-1 and flag the wrap cycle as the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCnt_q <= '0;
      tick_q   <= 1'b0;
    end else if (divCnt_q == CW'(DIV - 1)) begin
      divCnt_q <= '0;
      tick_q   <= 1'b1;
    end else begin
      divCnt_q <= divCnt_q + 1'b1;
      tick_q   <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/dht11_driver.sv
// ---------------------------------------------------------------------------
// dht11_driver
//   Single-wire DHT11 bus master. A sample_en pulse starts a measurement:
//   the host pulls the line low for START_LOW_MS, releases it, follows the
//   sensor's 80/80 us response and then decodes 40 data bits by measuring
//   each high phase (>= BIT1_THRESH_US means '1'). Integer humidity and
//   temperature are presented with a 1-cycle data_rdy strobe; any phase that
//   exceeds TIMEOUT_US (or a bad checksum, when enabled) gives a 1-cycle err.
//   Ports:
//     clk       in     system clock
//     rst_n     in     asynchronous active-low reset
//     bus       slave  dht11_if (sample_en, busy, data_rdy, humidity,
//                      temperature, err)
//     dht11_io  inout  sensor line, driven 0 or Z only (external pull-up)
//   Configuration macro:
//     DHT11_CHECKSUM_EN  when defined, the frame is accepted only if
//                        (b4+b3+b2+b1) mod 256 == b0; otherwise the checksum
//                        byte is received and discarded.
// ---------------------------------------------------------------------------
module dht11_driver
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int START_LOW_MS   = 20,
  parameter int BIT1_THRESH_US = 40,
  parameter int TIMEOUT_US     = 200
) (
  input  logic    clk,
  input  logic    rst_n,
  dht11_if.slave  bus,
  inout  wire     dht11_io
);

  localparam logic [PHASE_W-1:0]   START_TICKS   = PHASE_W'(START_LOW_MS * US_PER_MS);
  localparam logic [PHASE_W-1:0]   BIT1_TICKS    = PHASE_W'(BIT1_THRESH_US);
  localparam logic [PHASE_W-1:0]   TIMEOUT_TICKS = PHASE_W'(TIMEOUT_US);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT      = BIT_CNT_W'(FRAME_BITS - 1);

  logic tick;

  dht11_us_tick #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Line sampling: two synchroniser stages plus one history stage for edges.
  // Reset to 1 (idle pulled-up level) so no spurious edge follows reset.
  logic sync1_q, sync2_q, prev_q;
  logic fallEdge, riseEdge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= dht11_io;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fallEdge = prev_q & ~sync2_q;
  assign riseEdge = ~prev_q & sync2_q;

  dht11_state_e           state_q;
  logic [PHASE_W-1:0]     phaseCnt_q, phaseCnt_d;
  logic [BIT_CNT_W-1:0]   bitCnt_q;
  logic [FRAME_BITS-1:0]  frame_q;
  logic                   driveLow_q;
  logic                   busy_q;
  logic                   dataRdy_q;
  logic                   err_q;
  logic [7:0]             humidity_q;
  logic [7:0]             temperature_q;
  logic                   timedOut;
  logic                   frameOk;

  // Phase length including the tick of the current cycle, so the edge that
  // closes a phase sees every tick the phase spanned. Saturates at all-ones.
  always_comb begin
    phaseCnt_d = phaseCnt_q;
    if (tick && (phaseCnt_q != '1)) begin
      phaseCnt_d = phaseCnt_q + 1'b1;
    end
  end

  assign timedOut = (phaseCnt_d >= TIMEOUT_TICKS);

`ifdef DHT11_CHECKSUM_EN
  logic [7:0] frameSum;

  always_comb begin
    frameSum = frameByte(frame_q, RH_INT_IDX) + frameByte(frame_q, RH_DEC_IDX)
             + frameByte(frame_q, T_INT_IDX)  + frameByte(frame_q, T_DEC_IDX);
  end

  assign frameOk = (frameSum == frameByte(frame_q, CSUM_IDX));
`else
  logic unusedFrameBits;

  assign unusedFrameBits = ^{frameByte(frame_q, RH_DEC_IDX),
                             frameByte(frame_q, T_DEC_IDX),
                             frameByte(frame_q, CSUM_IDX)};
  assign frameOk = 1'b1;
`endif

  // Main sequencer. Every state change clears the phase counter so each
  // phase is timed from its own start. In every wait state the edge test
  // comes before the timeout test, so an edge on the expiry cycle wins.
  // data_rdy/err are set on entry to DONE/ERROR and are therefore high for
  // exactly the one cycle spent there; busy falls as IDLE is re-entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      phaseCnt_q    <= '0;
      bitCnt_q      <= '0;
      frame_q       <= '0;
      driveLow_q    <= 1'b0;
      busy_q        <= 1'b0;
      dataRdy_q     <= 1'b0;
      err_q         <= 1'b0;
      humidity_q    <= '0;
      temperature_q <= '0;
    end else begin
      dataRdy_q  <= 1'b0;
      err_q      <= 1'b0;
      phaseCnt_q <= phaseCnt_d;

      case (state_q)
        ST_IDLE: begin
          phaseCnt_q <= '0;
          if (bus.sample_en) begin
            state_q    <= ST_START_LOW;
            busy_q     <= 1'b1;
            driveLow_q <= 1'b1;
          end
        end

        ST_START_LOW: begin
          if (phaseCnt_d >= START_TICKS) begin
            state_q    <= ST_RELEASE;
            driveLow_q <= 1'b0;
            phaseCnt_q <= '0;
          end
        end

        ST_RELEASE: begin
          if (fallEdge) begin
            state_q    <= ST_RESP_LOW;
            phaseCnt_q <= '0;
          end else if (timedOut) begin
            state_q <= ST_ERROR;
            err_q   <= 1'b1;
          end
        end

        ST_RESP_LOW: begin
          if (riseEdge) begin
            state_q    <= ST_RESP_HIGH;
            phaseCnt_q <= '0;
          end else if (timedOut) begin
            state_q <= ST_ERROR;
            err_q   <= 1'b1;
          end
        end

        ST_RESP_HIGH: begin
          if (fallEdge) begin
            state_q    <= ST_BIT_LOW;
            bitCnt_q   <= '0;
            phaseCnt_q <= '0;
          end else if (timedOut) begin
            state_q <= ST_ERROR;
            err_q   <= 1'b1;
          end
        end

        ST_BIT_LOW: begin
          if (riseEdge) begin
            state_q    <= ST_BIT_HIGH;
            phaseCnt_q <= '0;
          end else if (timedOut) begin
            state_q <= ST_ERROR;
            err_q   <= 1'b1;
          end
        end

        ST_BIT_HIGH: begin
          if (fallEdge) begin
            frame_q    <= {frame_q[FRAME_BITS-2:0], (phaseCnt_d >= BIT1_TICKS)};
            phaseCnt_q <= '0;
            if (bitCnt_q == LAST_BIT) begin
              state_q <= ST_CHECK;
            end else begin
              state_q  <= ST_BIT_LOW;
              bitCnt_q <= bitCnt_q + 1'b1;
            end
          end else if (timedOut) begin
            state_q <= ST_ERROR;
            err_q   <= 1'b1;
          end
        end

        ST_CHECK: begin
          phaseCnt_q <= '0;
          if (frameOk) begin
            state_q       <= ST_DONE;
            dataRdy_q     <= 1'b1;
            humidity_q    <= frameByte(frame_q, RH_INT_IDX);
            temperature_q <= frameByte(frame_q, T_INT_IDX);
          end else begin
            state_q <= ST_ERROR;
            err_q   <= 1'b1;
          end
        end

        ST_DONE, ST_ERROR: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          phaseCnt_q <= '0;
        end

        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          driveLow_q <= 1'b0;
          phaseCnt_q <= '0;
        end
      endcase
    end
  end

  // Open-drain style: the line is only ever pulled low, never driven high.
  assign dht11_io = driveLow_q ? 1'b0 : 1'bz;

  assign bus.busy        = busy_q;
  assign bus.data_rdy    = dataRdy_q;
  assign bus.err         = err_q;
  assign bus.humidity    = humidity_q;
  assign bus.temperature = temperature_q;

endmodule

// File: tb/tb_dht11_driver.sv
// ---------------------------------------------------------------------------
// tb_dht11_driver
//   Directed bench for dht11_driver with a behavioural DHT11 on a pulled-up
//   line. The clock is scaled to 2 MHz (2 cycles per microsecond) and the
//   start pulse to 1 ms so a full frame takes about 9-10k cycles.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dht11_driver;

  localparam int CLK_HZ     = 2_000_000;
  localparam int CYC_PER_US = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic sensorLow;
  logic startWindow;

  wire dhtLine;
  pullup (dhtLine);
  assign dhtLine = sensorLow ? 1'b0 : 1'bz;

  dht11_if ifc ();

  dht11_driver #(
    .CLK_FREQ_HZ    (CLK_HZ),
    .START_LOW_MS   (1),
    .BIT1_THRESH_US (40),
    .TIMEOUT_US     (200)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifc),
    .dht11_io (dhtLine)
  );

  always #250 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  int rdyCount    = 0;
  int errCount    = 0;
  int bothHigh    = 0;
  int hostLowViol = 0;
  logic [7:0] rdyHum  = '0;
  logic [7:0] rdyTemp = '0;

  // Single comparison point: counts, and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Per-cycle monitor, sampled mid-way between clock edges. The line may be
  // low only while the sensor pulls it or while the host start pulse is due.
  always begin
    @(negedge clk);
    #100;
    if (ifc.data_rdy === 1'b1) begin
      rdyCount++;
      rdyHum  = ifc.humidity;
      rdyTemp = ifc.temperature;
    end
    if (ifc.err === 1'b1) errCount++;
    if (ifc.data_rdy === 1'b1 && ifc.err === 1'b1) bothHigh++;
    if (dhtLine === 1'b0 && !sensorLow && !startWindow) hostLowViol++;
    if (dhtLine !== 1'b0 && dhtLine !== 1'b1) hostLowViol++;
  end

  // Holds the sensor side of the line for 'us' microseconds; also retires
  // any one-cycle sample_en pulse raised just before the call.
  task automatic holdLevel(input logic low, input int us);
    sensorLow = low;
    repeat (us * CYC_PER_US) begin
      @(negedge clk);
      ifc.sample_en = 1'b0;
    end
  endtask

  task automatic clearCounters();
    rdyCount = 0;
    errCount = 0;
  endtask

  // Requests a measurement and plays the sensor side of one transaction.
  // oneUs: high time used for '1' bits ('0' bits are always 26 us).
  // pokeAtBit / resetAtBit: bit index (0 = first) at which to pulse
  // sample_en or assert reset mid high phase; -1 disables.
  task automatic applyStimulus(input logic [39:0] frame, input int oneUs,
                               input bit silent, input int pokeAtBit,
                               input int resetAtBit);
    int n;
    @(negedge clk);
    startWindow   = 1'b1;
    ifc.sample_en = 1'b1;
    @(negedge clk);
    ifc.sample_en = 1'b0;
    n = 0;
    while (dhtLine !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("start_pulse_seen", dhtLine === 1'b0, 1);
    n = 0;
    while (dhtLine === 1'b0 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    startWindow = 1'b0;
    checkOutput("start_pulse_len_1999_2000", (n >= 1998 && n <= 2001), 1);
    if (silent) return;

    holdLevel(1'b0, 30);
    holdLevel(1'b1, 80);
    holdLevel(1'b0, 80);
    for (int i = 0; i < 40; i++) begin
      if (i == pokeAtBit) ifc.sample_en = 1'b1;
      holdLevel(1'b1, 50);
      if (i == resetAtBit) begin
        holdLevel(1'b0, 20);
        rst_n = 1'b0;
        #50;
        checkOutput("midreset_line", dhtLine, 1);
        checkOutput("midreset_busy", ifc.busy, 0);
        checkOutput("midreset_hum", ifc.humidity, 0);
        checkOutput("midreset_temp", ifc.temperature, 0);
        checkOutput("midreset_rdy_err", {ifc.data_rdy, ifc.err}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      holdLevel(1'b0, frame[39 - i] ? oneUs : 26);
    end
    holdLevel(1'b1, 50);
    holdLevel(1'b0, 10);
  endtask

  task automatic expectFrame(input string name, input int expRdy, input int expErr,
                             input int hum, input int temp);
    repeat (4) @(negedge clk);
    checkOutput({name, "_rdy_count"}, rdyCount, expRdy);
    checkOutput({name, "_err_count"}, errCount, expErr);
    checkOutput({name, "_humidity"}, ifc.humidity, hum);
    checkOutput({name, "_temperature"}, ifc.temperature, temp);
    checkOutput({name, "_busy"}, ifc.busy, 0);
    if (expRdy > 0) begin
      checkOutput({name, "_strobe_hum"}, rdyHum, hum);
      checkOutput({name, "_strobe_temp"}, rdyTemp, temp);
    end
  endtask

  initial begin
    #40_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n         = 1'b0;
    sensorLow     = 1'b0;
    startWindow   = 1'b0;
    ifc.sample_en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", ifc.busy, 0);
    checkOutput("reset_rdy", ifc.data_rdy, 0);
    checkOutput("reset_err", ifc.err, 0);
    checkOutput("reset_hum", ifc.humidity, 0);
    checkOutput("reset_temp", ifc.temperature, 0);
    checkOutput("reset_line", dhtLine, 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // RH 55, T 25, correct checksum; '1' bits 70 us, '0' bits 26 us.
    $display("[TB] frame 37 00 19 00 50");
    clearCounters();
    applyStimulus(40'h37_00_19_00_50, 70, 1'b0, -1, -1);
    expectFrame("good", 1, 0, 55, 25);

    // Same data, wrong checksum byte.
    $display("[TB] frame 37 00 19 00 51");
    clearCounters();
    applyStimulus(40'h37_00_19_00_51, 70, 1'b0, -1, -1);
`ifdef DHT11_CHECKSUM_EN
    expectFrame("badsum", 0, 1, 55, 25);
`else
    expectFrame("badsum", 1, 0, 55, 25);
`endif

    // Sensor never answers: err 200 us (400 cycles) after release.
    $display("[TB] silent sensor");
    clearCounters();
    applyStimulus(40'h0, 70, 1'b1, -1, -1);
    n = 0;
    while (ifc.err !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("silent_err_delay_399_400", (n >= 398 && n <= 401), 1);
    checkOutput("silent_busy_at_err", ifc.busy, 1);
    @(negedge clk);
    checkOutput("silent_busy_after", ifc.busy, 0);
    checkOutput("silent_err_count", errCount, 1);
    checkOutput("silent_hum_held", ifc.humidity, 55);

    // '1' bits exactly at the 40 us threshold: RH 90, T 30, sum 0x78.
    $display("[TB] frame 5A 00 1E 00 78 with 40 us ones");
    clearCounters();
    applyStimulus(40'h5A_00_1E_00_78, 40, 1'b0, -1, -1);
    expectFrame("thresh", 1, 0, 90, 30);

    // sample_en pulsed mid-frame must be ignored: RH 45, T 22, sum 0x43.
    $display("[TB] frame 2D 00 16 00 43 with request at bit 10");
    clearCounters();
    applyStimulus(40'h2D_00_16_00_43, 70, 1'b0, 10, -1);
    expectFrame("poke", 1, 0, 45, 22);

    // Reset in the high phase of bit 20, then a clean frame.
    $display("[TB] reset during bit 20");
    clearCounters();
    applyStimulus(40'h37_00_19_00_50, 70, 1'b0, -1, 20);
    repeat (4) @(negedge clk);
    checkOutput("midreset_no_rdy", rdyCount, 0);
    clearCounters();
    applyStimulus(40'h37_00_19_00_50, 70, 1'b0, -1, -1);
    expectFrame("postreset", 1, 0, 55, 25);

    checkOutput("rdy_err_overlap", bothHigh, 0);
    checkOutput("unexpected_line_low", hostLowViol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
